mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous block RAM between the core's instruction-fetch requester and its data requester.
//  Sits between the core's fetch/load-store logic and the KGPRISC memory instance.
//  Issues at most one memory access per cycle and routes read data back to the issuing requester one cycle later.
//  Drives a stall to the core whenever a pending request is not granted.
// PARAMETERS
//  ADDR_W        32  memory address width
//  DATA_W        32  memory data width
//  STARVE_LIMIT  4   consecutive denied fetch cycles before fetch is forced; legal range 1..15
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  if_req     in   1       fetch read request; held until if_gnt
//  if_addr    in   ADDR_W  fetch address; sampled in the if_gnt cycle
//  if_gnt     out  1       fetch access issued this cycle
//  if_rvalid  out  1       fetch read data valid
//  if_rdata   out  DATA_W  fetch read data
//  d_req      in   1       data request; held until d_gnt
//  d_we       in   1       1 = write, 0 = read
//  d_addr     in   ADDR_W  data address; sampled in the d_gnt cycle
//  d_wdata    in   DATA_W  write data; sampled in the d_gnt cycle
//  d_gnt      out  1       data access issued this cycle
//  d_rvalid   out  1       data read data valid; never asserted for writes
//  d_rdata    out  DATA_W  data read data
//  mem_en     out  1       RAM enable
//  mem_we     out  1       RAM write enable
//  mem_addr   out  ADDR_W  RAM address
//  mem_din    out  DATA_W  RAM write data
//  mem_dout   in   DATA_W  RAM read data; valid the cycle after a read is issued
//  stall      out  1       (if_req & ~if_gnt) | (d_req & ~d_gnt)
// BEHAVIOUR
//  - Grant logic is combinational in the request cycle.
//    - Only one requester active: that requester is granted.
//    - Both requesting: d wins (strict priority), except under the starvation guard (see CONFIGURATION).
//  - Granted port drives mem_*; mem_en = if_gnt | d_gnt.
//    - mem_we = d_gnt & d_we.
//    - When idle: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
//  - Return FSM (registered), states RET_NONE, RET_IF, RET_D.
//    - Next state: RET_IF on a fetch grant; RET_D on a data read grant; otherwise RET_NONE (writes included).
//    - Read latency is exactly 1 cycle: in RET_IF, if_rvalid=1 and if_rdata=mem_dout; in RET_D, d_rvalid=1 and d_rdata=mem_dout.
//    - *_rdata = 0 when the matching rvalid = 0.
//  - Fully pipelined: a new grant may issue in the same cycle a previous read returns. Throughput is 1 access/cycle.
//  - Request dropped before grant: no access is issued and no stall is raised for that port.
//  - While reset=1: gnt, rvalid, mem_en, mem_we and stall are all forced to 0; the FSM goes to RET_NONE; the starvation counter clears.
//  - Reset asserted the cycle after a grant: the in-flight read is dropped and no rvalid is produced.
//  - After reset is released: normal arbitration resumes in the first cycle; nothing is held over.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//    - 4-bit counter starve_cnt increments each cycle with if_req & ~if_gnt, saturating at 15.
//    - Clears on if_gnt, on if_req=0, or on reset.
//    - When starve_cnt == STARVE_LIMIT and both are requesting, fetch wins that cycle.
//  ARB_STARVE_GUARD_EN undefined:
//    - No counter; strict d priority always applies.
//    - Fetch can be starved indefinitely.
// TESTING
//  1. Reset held 2 cycles with if_req=d_req=1 -> all gnt/rvalid/mem_en/stall = 0 throughout.
//  2. Lone fetch, if_addr=0x10, RAM[0x10]=0xDEADBEEF -> if_gnt=1, mem_en=1, mem_we=0, mem_addr=0x10; next cycle if_rvalid=1, if_rdata=0xDEADBEEF.
//  3. Both request, d read of 0x20 (0x0BADF00D) -> d_gnt=1, stall=1; next cycle d_rvalid=1, d_rdata=0x0BADF00D; with d_req=0, if_gnt=1 that cycle.
//  4. d write 0x30 <= 0x12345678 -> mem_we=1, mem_din=0x12345678, no d_rvalid next cycle; d read of 0x30 returns 0x12345678.
//  5. Both held 6 cycles, STARVE_LIMIT=4:
//     - Guard on: d_gnt in cycles 0-3, if_gnt in cycle 4, d_gnt in cycle 5.
//     - Guard off: d_gnt in all 6 cycles.
//  6. Lone fetch granted, reset=1 next cycle -> if_rvalid stays 0; after release, a fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sync RAM between fetch and data requesters, routing read data back one cycle later.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              stall
);
  typedef enum logic [1:0] {RET_NONE, RET_IF, RET_D} ret_t;
  ret_t r_state, w_next;
  logic w_force_if;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_starve_cnt <= '0;
    else if (if_req & ~if_gnt) r_starve_cnt <= (r_starve_cnt == 4'd15) ? r_starve_cnt : r_starve_cnt + 4'd1;
    else r_starve_cnt <= '0;
  end
  assign w_force_if = (r_starve_cnt == 4'(STARVE_LIMIT));
`else
  assign w_force_if = 1'b0;
`endif
  // Data has strict priority unless the guard hands this cycle to a starved fetch.
  always_comb begin
    if_gnt    = ~reset & if_req & (~d_req | w_force_if);
    d_gnt     = ~reset & d_req & ~(if_req & w_force_if);
    stall     = ~reset & ((if_req & ~if_gnt) | (d_req & ~d_gnt));
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = if_gnt ? if_addr : d_gnt ? d_addr : '0;
    mem_din   = mem_we ? d_wdata : '0;
    if_rvalid = ~reset & (r_state == RET_IF);
    d_rvalid  = ~reset & (r_state == RET_D);
    if_rdata  = if_rvalid ? mem_dout : '0;
    d_rdata   = d_rvalid ? mem_dout : '0;
    w_next    = if_gnt ? RET_IF : (d_gnt & ~d_we) ? RET_D : RET_NONE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= RET_NONE;
    else r_state <= w_next;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector bench for mem_port_arbiter with a behavioural RAM.
module tb_mem_port_arbiter;
  logic clk = 0, reset = 1;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_din, mem_dout;
  logic [31:0] ram [256];
  int n_vec = 0, n_bad = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .stall(stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_din;
    else mem_dout <= ram[mem_addr[7:0]];
  end

  typedef struct {
    logic rst, ir; logic [31:0] ia; logic dr, dwe; logic [31:0] da, wd;
    logic eig, edg, est, een, ewe; logic [31:0] ema, emd;
    logic eirv; logic [31:0] eird; logic edrv; logic [31:0] edrd;
  } vec_t;

  function automatic vec_t mk(logic rst, ir, logic [31:0] ia, logic dr, dwe, logic [31:0] da, wd,
                              logic eig, edg, est, een, ewe, logic [31:0] ema, emd,
                              logic eirv, logic [31:0] eird, logic edrv, logic [31:0] edrd);
    mk = '{rst, ir, ia, dr, dwe, da, wd, eig, edg, est, een, ewe, ema, emd, eirv, eird, edrv, edrd};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic rst, ir, input logic [31:0] ia, input logic dr, dwe, input logic [31:0] da, wd);
    @(negedge clk);
    reset = rst; if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = wd;
    #1;
  endtask

  vec_t v [11];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram['h10] = 32'hDEADBEEF;
    ram['h14] = 32'hCAFEF00D;
    ram['h20] = 32'h0BADF00D;
    v[0]  = mk(1, 1, 'h10, 1, 0, 'h20, 0,            0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0);
    v[1]  = mk(1, 1, 'h10, 1, 0, 'h20, 0,            0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0);
    v[2]  = mk(0, 1, 'h10, 0, 0, 0, 0,               1, 0, 0, 1, 0, 'h10, 0,             0, 0, 0, 0);
    v[3]  = mk(0, 1, 'h14, 1, 0, 'h20, 0,            0, 1, 1, 1, 0, 'h20, 0,             1, 'hDEADBEEF, 0, 0);
    v[4]  = mk(0, 1, 'h14, 0, 0, 0, 0,               1, 0, 0, 1, 0, 'h14, 0,             0, 0, 1, 'h0BADF00D);
    v[5]  = mk(0, 0, 0, 1, 1, 'h30, 'h12345678,      0, 1, 0, 1, 1, 'h30, 'h12345678,    1, 'hCAFEF00D, 0, 0);
    v[6]  = mk(0, 0, 0, 1, 0, 'h30, 'hFFFFFFFF,      0, 1, 0, 1, 0, 'h30, 0,             0, 0, 0, 0);
    v[7]  = mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 0,                0, 0, 1, 'h12345678);
    v[8]  = mk(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0);
    v[9]  = mk(0, 1, 'h10, 1, 0, 'h20, 0,            0, 1, 1, 1, 0, 'h20, 0,             0, 0, 0, 0);
    v[10] = mk(0, 0, 'h10, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0,                0, 0, 1, 'h0BADF00D);
    for (int i = 0; i < 11; i++) begin
      drive(v[i].rst, v[i].ir, v[i].ia, v[i].dr, v[i].dwe, v[i].da, v[i].wd);
      chk($sformatf("v%0d if_gnt", i), 32'(if_gnt), 32'(v[i].eig));
      chk($sformatf("v%0d d_gnt", i), 32'(d_gnt), 32'(v[i].edg));
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(v[i].est));
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(v[i].een));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v[i].ewe));
      chk($sformatf("v%0d mem_addr", i), mem_addr, v[i].ema);
      chk($sformatf("v%0d mem_din", i), mem_din, v[i].emd);
      chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid), 32'(v[i].eirv));
      chk($sformatf("v%0d if_rdata", i), if_rdata, v[i].eird);
      chk($sformatf("v%0d d_rvalid", i), 32'(d_rvalid), 32'(v[i].edrv));
      chk($sformatf("v%0d d_rdata", i), d_rdata, v[i].edrd);
    end
    // Both requesters held for six cycles: starvation guard behaviour.
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      logic exp_if;
`ifdef ARB_STARVE_GUARD_EN
      exp_if = (i == 4);
`else
      exp_if = 1'b0;
`endif
      drive(0, 1, 'h10, 1, 0, 'h20, 0);
      chk($sformatf("starve c%0d if_gnt", i), 32'(if_gnt), 32'(exp_if));
      chk($sformatf("starve c%0d d_gnt", i), 32'(d_gnt), 32'(!exp_if));
      chk($sformatf("starve c%0d stall", i), 32'(stall), 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // Reset right after a fetch grant drops the in-flight read.
    drive(0, 1, 'h10, 0, 0, 0, 0);
    chk("rst_flight if_gnt", 32'(if_gnt), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("rst_flight if_rvalid in reset", 32'(if_rvalid), 32'd0);
    chk("rst_flight if_rdata in reset", if_rdata, 32'd0);
    chk("rst_flight mem_en in reset", 32'(mem_en), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_flight if_rvalid after", 32'(if_rvalid), 32'd0);
    drive(0, 1, 'h14, 0, 0, 0, 0);
    chk("post_rst if_gnt", 32'(if_gnt), 32'd1);
    chk("post_rst mem_addr", mem_addr, 32'h14);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst if_rvalid", 32'(if_rvalid), 32'd1);
    chk("post_rst if_rdata", if_rdata, 32'hCAFEF00D);
    chk("post_rst d_rvalid", 32'(d_rvalid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
